// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 16x-oversampled UART receiver.
// Frame: start, 8 data bits LSB first, parity (XOR(data) ^ PARITY_MODE), stop.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority at every sample point,
// which adds one clock to all decision points (rdsig latency 167 instead of 166).
module uart_rx_16x #(
  parameter logic PARITY_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] SampleOfs = 8'd1;
`else
  localparam logic [7:0] SampleOfs = 8'd0;
`endif
  localparam logic [7:0] StartPt  = 8'd8   + SampleOfs;
  localparam logic [7:0] FirstPt  = 8'd24  + SampleOfs;
  localparam logic [7:0] ParityPt = 8'd152 + SampleOfs;
  localparam logic [7:0] StopPt   = 8'd164 + SampleOfs;
  localparam logic [7:0] DonePt   = StopPt + 8'd1;

  logic       sync1_q, sync2_q, hist_q;
  logic [1:0] flush_q;
  logic       armed_q, armed_d;
  logic       bit_smp;
  logic       start_det;
  logic [7:0] data_pt;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_bad_q, par_bad_d;
  logic       stop_q, stop_d;
  logic [7:0] dataout_q, dataout_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;
  logic       rdsig_q, rdsig_d;

  // Two-flop synchronizer plus one history flop; all idle-high after reset.
  // flush_q marks when sync2_q holds a real line sample rather than its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      flush_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      flush_q <= {flush_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  // A start needs a genuine high seen after reset, so a line held low at release is ignored.
  always_comb begin
    armed_d = armed_q | (flush_q[1] & sync2_q);
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist2_q;

  // Third tap: at cnt = N+1, hist2_q/hist_q/sync2_q hold rx at N-1/N/N+1.
  always_ff @(posedge clk) begin
    if (rst) hist2_q <= 1'b1;
    else     hist2_q <= hist_q;
  end

  // 2-of-3 vote rejects a single-clock glitch at the sample point.
  always_comb begin
    bit_smp = (hist2_q & hist_q) | (hist2_q & sync2_q) | (hist_q & sync2_q);
  end
`else
  // Single sample at the nominal bit centre.
  always_comb begin
    bit_smp = sync2_q;
  end
`endif

  // Receive FSM next-state: sample points are fixed cnt values from the start edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (state_q == StIdle) ? 8'd0 : cnt_q + 8'd1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    stop_d       = stop_q;
    dataout_d    = dataout_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;
    rdsig_d      = 1'b0;
    start_det    = armed_q & hist_q & ~sync2_q;
    data_pt      = FirstPt + {1'b0, bit_q, 4'b0000};
    case (state_q)
      StIdle: begin
        if (start_det) begin
          state_d = StStart;
          cnt_d   = 8'd1;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == StartPt) begin
          if (!bit_smp) begin
            state_d = StData;
            bit_d   = 3'd0;
          end else begin
            // False start: drop back silently, outputs untouched.
            state_d = StIdle;
            cnt_d   = 8'd0;
            busy_d  = 1'b0;
          end
        end
      end
      StData: begin
        if (cnt_q == data_pt) begin
          shift_d = {bit_smp, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (cnt_q == ParityPt) begin
          par_bad_d = bit_smp ^ (^shift_q) ^ PARITY_MODE;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (cnt_q == StopPt) stop_d = bit_smp;
        if (cnt_q == DonePt) begin
          dataout_d    = shift_q;
          parity_err_d = par_bad_q;
          frame_err_d  = ~stop_q;
          rdsig_d      = 1'b1;
          busy_d       = 1'b0;
          state_d      = StIdle;
          cnt_d        = 8'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Receive FSM state and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      par_bad_q    <= 1'b0;
      stop_q       <= 1'b1;
      dataout_q    <= 8'h00;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      rdsig_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      stop_q       <= stop_d;
      dataout_q    <= dataout_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      rdsig_q      <= rdsig_d;
    end
  end

  assign dataout    = dataout_q;
  assign rdsig      = rdsig_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Testbench for uart_rx_16x: bit-level transmitter model, rdsig/busy monitor and
// per-scenario checks against expectations computed from the frame definition.
module tb_uart_rx_16x;

  localparam logic PM = 1'b0;
`ifdef UART_RX_MAJORITY_EN
  localparam int Lat = 167;
  localparam int Ofs = 1;
`else
  localparam int Lat = 166;
  localparam int Ofs = 0;
`endif
  localparam int Sync = 2;     // line fall to synchronized fall
  localparam int FrameLen = 168; // 10 bits of 16 clocks + 8-clock stop

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b0;
  logic [7:0] dataout;
  logic       rdsig, parity_err, frame_err, busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int busy_cnt = 0;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ev_t;
  ev_t evq[$];

  // Expected outputs after the most recent completed frame.
  logic [7:0] last_d;
  logic       last_pe, last_fe;

  uart_rx_16x #(.PARITY_MODE(PM)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .dataout   (dataout),
    .rdsig     (rdsig),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every rdsig cycle with its outputs and count busy cycles.
  always begin
    @(posedge clk);
    #1;
    if (busy === 1'b1) busy_cnt++;
    if (rdsig === 1'b1) evq.push_back(ev_t'{cyc: cyc, d: dataout, pe: parity_err, fe: frame_err});
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PM;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transmitter model: start, 8 data LSB first, parity, stop of given level/length.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_lvl,
                            input int stop_len, output int fall);
    fall = cyc;
    rx = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(16);
    end
    rx = pbit;
    wait_clk(16);
    rx = stop_lvl;
    wait_clk(stop_len);
  endtask

  task automatic test_reset;
    int b0, e0;
    rst = 1'b1;
    rx  = 1'b0;
    wait_clk(3);
    n_checks++;
    if (dataout !== 8'h00) begin
      n_fail++; $display("FAIL reset_dataout got %h want 00", dataout);
    end
    n_checks++;
    if ({busy, rdsig, parity_err, frame_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got b%b r%b p%b f%b want all 0", busy, rdsig, parity_err,
               frame_err);
    end
    b0 = busy_cnt;
    e0 = evq.size();
    rst = 1'b0;
    wait_clk(40);
    n_checks++;
    if (busy_cnt - b0 != 0 || evq.size() != e0) begin
      n_fail++;
      $display("FAIL low_at_release busy_cycles %0d events %0d want 0 0", busy_cnt - b0,
               evq.size() - e0);
    end
    rx = 1'b1;
    wait_clk(10);
    last_d = 8'h00; last_pe = 1'b0; last_fe = 1'b0;
  endtask

  task automatic test_clean;
    int b0, e0, fall;
    b0 = busy_cnt;
    e0 = evq.size();
    send_frame(8'h55, good_par(8'h55), 1'b1, 8, fall);
    wait_clk(30);
    n_checks++;
    if (evq.size() - e0 != 1) begin
      n_fail++; $display("FAIL clean_count got %0d want 1", evq.size() - e0);
    end else begin
      n_checks++;
      if (evq[e0].cyc != fall + Sync + Lat) begin
        n_fail++; $display("FAIL clean_latency got %0d want %0d", evq[e0].cyc - fall - Sync, Lat);
      end
      n_checks++;
      if ({evq[e0].d, evq[e0].pe, evq[e0].fe} !== {8'h55, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL clean_data got %h p%b f%b want 55 p0 f0", evq[e0].d, evq[e0].pe,
                 evq[e0].fe);
      end
    end
    // busy rises on the edge after the synchronized fall and drops with rdsig.
    n_checks++;
    if (busy_cnt - b0 != Lat - 1) begin
      n_fail++; $display("FAIL clean_busy_len got %0d want %0d", busy_cnt - b0, Lat - 1);
    end
    last_d = 8'h55; last_pe = 1'b0; last_fe = 1'b0;
  endtask

  task automatic test_parity;
    int e0, fall;
    logic exp_pe;
    e0 = evq.size();
    exp_pe = (1'b1 != good_par(8'hA3));
    send_frame(8'hA3, 1'b1, 1'b1, 8, fall);
    wait_clk(30);
    n_checks++;
    if (evq.size() - e0 != 1) begin
      n_fail++; $display("FAIL parity_count got %0d want 1", evq.size() - e0);
    end else begin
      n_checks++;
      if ({evq[e0].d, evq[e0].pe, evq[e0].fe} !== {8'hA3, exp_pe, 1'b0} ||
          evq[e0].cyc != fall + Sync + Lat) begin
        n_fail++;
        $display("FAIL parity_err got %h p%b f%b @%0d want a3 p%b f0 @%0d", evq[e0].d,
                 evq[e0].pe, evq[e0].fe, evq[e0].cyc, exp_pe, fall + Sync + Lat);
      end
    end
    last_d = 8'hA3; last_pe = exp_pe; last_fe = 1'b0;
  endtask

  task automatic test_frame_err;
    int b0, e0, fall;
    logic [7:0] d2;
    b0 = busy_cnt;
    e0 = evq.size();
    send_frame(8'h0F, good_par(8'h0F), 1'b0, 40, fall);
    n_checks++;
    if (evq.size() - e0 != 1) begin
      n_fail++; $display("FAIL frame_count got %0d want 1", evq.size() - e0);
    end else begin
      n_checks++;
      if ({evq[e0].d, evq[e0].pe, evq[e0].fe} !== {8'h0F, 1'b0, 1'b1} ||
          evq[e0].cyc != fall + Sync + Lat) begin
        n_fail++;
        $display("FAIL frame_err got %h p%b f%b @%0d want 0f p0 f1 @%0d", evq[e0].d,
                 evq[e0].pe, evq[e0].fe, evq[e0].cyc, fall + Sync + Lat);
      end
    end
    // Line still low: no new frame may have started.
    n_checks++;
    if (busy !== 1'b0 || busy_cnt - b0 != Lat - 1) begin
      n_fail++;
      $display("FAIL frame_no_restart busy %b busy_cycles %0d want 0 %0d", busy, busy_cnt - b0,
               Lat - 1);
    end
    rx = 1'b1;
    wait_clk(20);
    d2 = 8'($urandom);
    e0 = evq.size();
    send_frame(d2, good_par(d2), 1'b1, 8, fall);
    wait_clk(30);
    n_checks++;
    if (evq.size() - e0 != 1) begin
      n_fail++; $display("FAIL frame_recover_count got %0d want 1", evq.size() - e0);
    end else begin
      n_checks++;
      if ({evq[e0].d, evq[e0].pe, evq[e0].fe} !== {d2, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL frame_recover got %h p%b f%b want %h p0 f0", evq[e0].d, evq[e0].pe,
                 evq[e0].fe, d2);
      end
    end
    last_d = d2; last_pe = 1'b0; last_fe = 1'b0;
  endtask

  task automatic test_false_start;
    int b0, e0;
    b0 = busy_cnt;
    e0 = evq.size();
    rx = 1'b0;
    wait_clk(4);
    rx = 1'b1;
    wait_clk(40);
    n_checks++;
    if (busy_cnt - b0 != 8 + Ofs) begin
      n_fail++; $display("FAIL false_start_busy got %0d want %0d", busy_cnt - b0, 8 + Ofs);
    end
    n_checks++;
    if (evq.size() != e0) begin
      n_fail++; $display("FAIL false_start_rdsig got %0d pulses want 0", evq.size() - e0);
    end
    n_checks++;
    if ({dataout, parity_err, frame_err} !== {last_d, last_pe, last_fe}) begin
      n_fail++;
      $display("FAIL false_start_outputs got %h p%b f%b want %h p%b f%b", dataout, parity_err,
               frame_err, last_d, last_pe, last_fe);
    end
  endtask

  task automatic test_back_to_back;
    int e0, f1, f2;
    e0 = evq.size();
    send_frame(8'h12, good_par(8'h12), 1'b1, 8, f1);
    send_frame(8'h34, good_par(8'h34), 1'b1, 8, f2);
    wait_clk(30);
    n_checks++;
    if (evq.size() - e0 != 2) begin
      n_fail++; $display("FAIL b2b_count got %0d want 2", evq.size() - e0);
    end else begin
      n_checks++;
      if ({evq[e0].d, evq[e0].pe, evq[e0].fe} !== {8'h12, 1'b0, 1'b0} ||
          evq[e0].cyc != f1 + Sync + Lat) begin
        n_fail++;
        $display("FAIL b2b_first got %h p%b f%b @%0d want 12 p0 f0 @%0d", evq[e0].d,
                 evq[e0].pe, evq[e0].fe, evq[e0].cyc, f1 + Sync + Lat);
      end
      n_checks++;
      if ({evq[e0+1].d, evq[e0+1].pe, evq[e0+1].fe} !== {8'h34, 1'b0, 1'b0} ||
          evq[e0+1].cyc != f1 + FrameLen + Sync + Lat) begin
        n_fail++;
        $display("FAIL b2b_second got %h p%b f%b @%0d want 34 p0 f0 @%0d", evq[e0+1].d,
                 evq[e0+1].pe, evq[e0+1].fe, evq[e0+1].cyc, f1 + FrameLen + Sync + Lat);
      end
    end
    last_d = 8'h34; last_pe = 1'b0; last_fe = 1'b0;
  endtask

  task automatic test_random_stream;
    ev_t expq[$];
    int e0, fall, slen;
    logic [7:0] d;
    logic flip;
    e0 = evq.size();
    for (int i = 0; i < 14; i++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      slen = 8 + int'($urandom_range(0, 12));
      send_frame(d, good_par(d) ^ flip, 1'b1, slen, fall);
      expq.push_back(ev_t'{cyc: fall + Sync + Lat, d: d, pe: flip, fe: 1'b0});
    end
    wait_clk(30);
    n_checks++;
    if (evq.size() - e0 != expq.size()) begin
      n_fail++; $display("FAIL rand_count got %0d want %0d", evq.size() - e0, expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        n_checks++;
        if ({evq[e0+i].d, evq[e0+i].pe, evq[e0+i].fe} !== {expq[i].d, expq[i].pe, expq[i].fe} ||
            evq[e0+i].cyc != expq[i].cyc) begin
          n_fail++;
          $display("FAIL rand_frame%0d got %h p%b f%b @%0d want %h p%b f%b @%0d", i,
                   evq[e0+i].d, evq[e0+i].pe, evq[e0+i].fe, evq[e0+i].cyc, expq[i].d,
                   expq[i].pe, expq[i].fe, expq[i].cyc);
        end
      end
      last_d = expq[expq.size()-1].d;
      last_pe = expq[expq.size()-1].pe;
      last_fe = 1'b0;
    end
  endtask

  task automatic test_reset_midframe;
    int e0, fall;
    // Known non-zero contents before the abort.
    e0 = evq.size();
    send_frame(8'h3C, good_par(8'h3C), 1'b1, 8, fall);
    wait_clk(20);
    n_checks++;
    if (evq.size() - e0 != 1 || dataout !== 8'h3C) begin
      n_fail++;
      $display("FAIL pre_abort_frame got %0d pulses data %h want 1 3c", evq.size() - e0, dataout);
    end
    // Frame 0xFF: start then all-ones data; reset lands while cnt = 70.
    e0 = evq.size();
    fall = cyc;
    rx = 1'b0;
    wait_clk(16);
    rx = 1'b1;
    wait_clk(Sync + 70 - 16);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_busy_before got %b want 1", busy);
    end
    rst = 1'b1;
    wait_clk(1);
    n_checks++;
    if ({busy, rdsig, parity_err, frame_err, dataout} !== {4'b0000, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_reset got b%b r%b p%b f%b d%h want 0 0 0 0 00", busy, rdsig,
               parity_err, frame_err, dataout);
    end
    rst = 1'b0;
    wait_clk(250);
    n_checks++;
    if (evq.size() != e0) begin
      n_fail++; $display("FAIL abort_rdsig got %0d pulses want 0", evq.size() - e0);
    end
    e0 = evq.size();
    send_frame(8'h81, good_par(8'h81), 1'b1, 8, fall);
    wait_clk(30);
    n_checks++;
    if (evq.size() - e0 != 1) begin
      n_fail++; $display("FAIL after_abort_count got %0d want 1", evq.size() - e0);
    end else begin
      n_checks++;
      if ({evq[e0].d, evq[e0].pe, evq[e0].fe} !== {8'h81, 1'b0, 1'b0} ||
          evq[e0].cyc != fall + Sync + Lat) begin
        n_fail++;
        $display("FAIL after_abort got %h p%b f%b @%0d want 81 p0 f0 @%0d", evq[e0].d,
                 evq[e0].pe, evq[e0].fe, evq[e0].cyc, fall + Sync + Lat);
      end
    end
  endtask

  initial begin
    wait_clk(1);
    test_reset();
    test_clean();
    test_parity();
    test_frame_err();
    test_false_start();
    test_back_to_back();
    test_random_stream();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
